prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets instruction-memory word-address width; maximum program depth is 2**ADDR_W words.
REQ-002 Parameter CYC_W, default 32, sets the run-cycle counter width.
REQ-003 Parameter MAX_CYCLES, default 100000, is the run-cycle limit before timeout; it SHALL fit in CYC_W bits.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_data  input  8  program byte stream from host.
REQ-007 in_valid  input  1  in_data holds a valid byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  16  instruction word.
REQ-012 cpu_n_rst  output  1  drives the CPU's active-low reset; high means the CPU runs.
REQ-013 cpu_halt  input  1  CPU halt indication.
REQ-014 done  output  1  the program halted or timed out.
REQ-015 timeout  output  1  the run ended by reaching MAX_CYCLES.
REQ-016 err  output  1  an illegal program length was received.
REQ-017 cycles  output  CYC_W  count of run cycles.

Function
REQ-018 The loader SHALL transfer a byte only on a rising edge where in_valid and in_ready are both 1.
REQ-019 The loader SHALL implement states LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, RUN, DONE and ERROR.
REQ-020 in_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA_LO, DATA_HI and DONE.
REQ-021 Stream format: length N, low byte first; then N words, each sent low byte first.
REQ-022 Length path: LEN_LO→LEN_HI on transfer; on the LEN_HI transfer, go to ERROR if N==0 or N>2**ADDR_W, else go to DATA_LO with word index 0.
REQ-023 Data path: DATA_LO→DATA_HI on transfer, and DATA_HI→WRITE on transfer.
REQ-024 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=index and imem_wdata={hi byte, lo byte}.
REQ-025 On leaving WRITE, the loader SHALL go to DATA_LO with index+1 if index<N-1, else to RUN.
REQ-026 imem_we SHALL be 0 in every state other than WRITE.
REQ-027 cpu_n_rst SHALL be 1 only in RUN and DONE; it SHALL rise the cycle after the final WRITE.
REQ-028 In RUN, the loader SHALL go to DONE with timeout=0 when cpu_halt=1, and cycles SHALL NOT increment that cycle.
REQ-029 In RUN with cpu_halt=0, cycles SHALL increment by 1.
REQ-030 When cycles reaches MAX_CYCLES, the loader SHALL go to DONE with timeout=1, and cycles SHALL hold MAX_CYCLES.
REQ-031 If cpu_halt=1 and the limit is reached in the same cycle, halt SHALL win and timeout SHALL be 0.
REQ-032 In DONE: done=1, and cycles and timeout hold their values.
REQ-033 A byte transferred in DONE SHALL be treated as a new LEN_LO byte: state→LEN_HI, and done, timeout and cycles clear to 0.
REQ-034 ERROR SHALL be sticky until rst: err=1, in_ready=0, cpu_n_rst=0, and no writes occur.
REQ-035 Length arithmetic is 16-bit unsigned, and index SHALL never wrap.

Reset
REQ-036 rst=1 at a rising edge SHALL override every other input, including mid-load and mid-run.
REQ-037 After the reset edge: state=LEN_LO, in_ready=1, and imem_we, imem_addr, imem_wdata, cpu_n_rst, done, timeout, err and cycles are all 0.
REQ-038 Bytes partially received before reset SHALL be discarded, and the next transferred byte SHALL be taken as a length low byte.

Verification
REQ-039 Load test: stream 03 00 34 12 CD AB 01 00 with in_valid held high → imem_we pulses at addr 0/1/2 with data 0x1234/0xABCD/0x0001, and cpu_n_rst rises the cycle after the third pulse.
REQ-040 Halt test: after the load, assert cpu_halt on the 11th RUN cycle → done=1, cycles=10, timeout=0, cpu_n_rst=1.
REQ-041 Timeout test: MAX_CYCLES=16 and cpu_halt held 0 → done=1, timeout=1, cycles=16; with halt coinciding with the limit → timeout=0.
REQ-042 Bad-length test: length 00 00 → err=1, in_ready=0, no imem_we; repeat with 01 01 (257) at ADDR_W=8 → err=1.
REQ-043 Back-pressure and reset test: random in_valid gaps produce writes identical to the load test; rst during DATA_HI → no further writes, in_ready=1, cpu_n_rst=0, and the next two bytes form a new length.
REQ-044 Restart test: from DONE, stream 01 00 EF BE → done clears, one write of 0xBEEF at addr 0, then RUN is re-entered with cycles restarting from 0.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Receives a program over a byte stream, writes it word by word into an
// instruction memory, then releases the CPU from reset and supervises the run
// until the CPU halts or a cycle limit is reached.
//
// Stream format: 16-bit word count N (low byte first), then N 16-bit words,
// each low byte first. Word i is written to imem address i.
//
// Handshake: a byte moves from host to loader on a rising clk edge where
// in_valid and in_ready are both 1. The host may hold in_valid high for any
// number of cycles; in_ready is a registered, state-derived output and never
// depends combinationally on in_valid.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_data      program byte from host
//   in_valid     in_data holds a valid byte
//   in_ready     loader accepts a byte this cycle
//   imem_we      instruction-memory write strobe (one cycle per word)
//   imem_addr    instruction-memory word address
//   imem_wdata   instruction word {hi byte, lo byte}
//   cpu_n_rst    CPU active-low reset; 1 while the CPU runs or is done
//   cpu_halt     CPU halt indication
//   done         run finished (halt or timeout)
//   timeout      run finished by hitting MAX_CYCLES
//   err          illegal program length received; sticky until rst
//   cycles       number of RUN cycles counted
//   dbg_state_o  current FSM state, for debug and checker binding
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_n_rst,
  input  logic              cpu_halt,
  output logic              done,
  output logic              timeout,
  output logic              err,
  output logic [CYC_W-1:0]  cycles,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_LEN_LO  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_WRITE   = 3'd4,
    S_RUN     = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  // Largest legal word count, 2**ADDR_W, held in 17 bits so that a 16-bit
  // length of 0xFFFF can be compared against 0x10000 without overflow.
  localparam logic [16:0] DEPTH = (ADDR_W >= 16) ? 17'h10000
                                                 : 17'(32'd1 << ADDR_W);

  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [7:0]          lo_q,       lo_d;       // pending low byte (length or data)
  logic [ADDR_W-1:0]   idx_q,      idx_d;      // word index, doubles as imem_addr
  logic [ADDR_W-1:0]   last_q,     last_d;     // index of the final word, N-1
  logic [15:0]         wdata_q,    wdata_d;
  logic [CYC_W-1:0]    cyc_q,      cyc_d;
  logic                tmo_q,      tmo_d;
  logic                ready_q,    ready_d;
  logic                we_q,       we_d;
  logic                nrst_q,     nrst_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;

  // ---------------------------------------------------------------------------
  // Helper signals
  // ---------------------------------------------------------------------------
  logic                xfer;
  logic [15:0]         len_w;
  logic                len_bad;
  logic [CYC_W-1:0]    cyc_inc;

  // ready_q mirrors the current state, so this is the real byte transfer.
  assign xfer    = in_valid & ready_q;

  // Full length once the high byte is on in_data.
  assign len_w   = {in_data, lo_q};
  assign len_bad = (len_w == 16'd0) || ({1'b0, len_w} > DEPTH);

  assign cyc_inc = cyc_q + CYC_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wdata_d = wdata_q;
    cyc_d   = cyc_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_LEN_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          state_d = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          if (len_bad) begin
            state_d = S_ERROR;
          end else begin
            // N is known to be 1..2**ADDR_W here, so N-1 fits in ADDR_W
            // bits and the index can never wrap.
            idx_d   = '0;
            last_d  = ADDR_W'(len_w - 16'd1);
            state_d = S_DATA_LO;
          end
        end
      end

      S_DATA_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          state_d = S_DATA_HI;
        end
      end

      S_DATA_HI: begin
        if (xfer) begin
          wdata_d = {in_data, lo_q};
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (idx_q == last_q) begin
          state_d = S_RUN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_DATA_LO;
        end
      end

      S_RUN: begin
        // A halt in the same cycle the limit would be hit wins: the counter
        // does not advance and the run is not flagged as a timeout.
        if (cpu_halt) begin
          tmo_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_inc;
          if (cyc_inc == CYC_LIMIT) begin
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Any byte here starts a new program: it is its length low byte.
        if (xfer) begin
          lo_d    = in_data;
          cyc_d   = '0;
          tmo_d   = 1'b0;
          state_d = S_LEN_HI;
        end
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_ERROR;
      end
    endcase

    // Outputs are decoded from the state being entered and registered, so
    // each output flop is aligned with the state register.
    ready_d = (state_d == S_LEN_LO)  || (state_d == S_LEN_HI) ||
              (state_d == S_DATA_LO) || (state_d == S_DATA_HI) ||
              (state_d == S_DONE);
    we_d    = (state_d == S_WRITE);
    nrst_d  = (state_d == S_RUN) || (state_d == S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERROR);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN_LO;
      lo_q    <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
      tmo_q   <= 1'b0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      nrst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
      cyc_q   <= cyc_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign in_ready    = ready_q;
  assign imem_we     = we_q;
  assign imem_addr   = idx_q;
  assign imem_wdata  = wdata_q;
  assign cpu_n_rst   = nrst_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign err         = err_q;
  assign cycles      = cyc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader (ADDR_W=8, MAX_CYCLES=16). The model
// works at stream level: from a word count and a word list it decides whether
// the length is legal, which (addr, data) writes must appear, and how long a
// run lasts and how it ends for a given halt cycle. A negedge monitor checks
// every write strobe against the expected queue.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int CYC_W  = 32;
  localparam int MAXC   = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_n_rst;
  logic              cpu_halt = 1'b0;
  logic              done;
  logic              timeout;
  logic              err;
  logic [CYC_W-1:0]  cycles;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W     (ADDR_W),
    .CYC_W      (CYC_W),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_n_rst   (cpu_n_rst),
    .cpu_halt    (cpu_halt),
    .done        (done),
    .timeout     (timeout),
    .err         (err),
    .cycles      (cycles),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];   // {addr16, data16} writes still expected
  logic [31:0] wlog[$];    // every write seen, for literal checks
  logic [31:0] e;
  int          cyc = 0;
  int          last_we_cyc = -100;
  logic        prev_nrst = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Compare process: every write strobe must match the head of exp_q, and
  // cpu_n_rst must rise exactly one cycle after the last write.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (imem_we) begin
        last_we_cyc = cyc;
        wlog.push_back({16'(imem_addr), imem_wdata});
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e[31:16]));
          check("write_data", 32'(imem_wdata), 32'(e[15:0]));
        end
        check("write_ready_low", 32'(in_ready), 0);
        check("write_cpu_held", 32'(cpu_n_rst), 0);
      end
      if (cpu_n_rst && !prev_nrst) check("nrst_rise_latency", cyc - last_we_cyc, 1);
      if (err) begin
        check("err_ready_low", 32'(in_ready), 0);
        check("err_cpu_held", 32'(cpu_n_rst), 0);
      end
    end
    prev_nrst = cpu_n_rst;
  end

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic bit len_legal(input int n);
    return (n >= 1) && (n <= DEPTH);
  endfunction

  task automatic rand_words(input int n, output logic [15:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(16'($urandom_range(0, 65535)));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    @(negedge clk);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: in_ready stayed 0, byte 0x%0h not accepted", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},   32'(in_ready), 1);
    check({tag, "_imem_we"},    32'(imem_we), 0);
    check({tag, "_imem_addr"},  32'(imem_addr), 0);
    check({tag, "_imem_wdata"}, 32'(imem_wdata), 0);
    check({tag, "_cpu_n_rst"},  32'(cpu_n_rst), 0);
    check({tag, "_done"},       32'(done), 0);
    check({tag, "_timeout"},    32'(timeout), 0);
    check({tag, "_err"},        32'(err), 0);
    check({tag, "_cycles"},     cycles, 0);
  endtask

  task automatic do_reset();
    check("pending_at_reset", exp_q.size(), 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    cpu_halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst");
  endtask

  // Sends a full program; for an illegal length only the header goes out
  // and the loader must be in its error state afterwards.
  task automatic load_prog(input int n, input logic [15:0] words[$], input bit gaps);
    logic [15:0] nn;
    logic [15:0] wd;
    nn = 16'(n);
    send_byte(nn[7:0], gaps);
    send_byte(nn[15:8], gaps);
    if (!len_legal(n)) begin
      repeat (2) @(negedge clk);
      check("bad_len_err", 32'(err), 1);
      check("bad_len_ready", 32'(in_ready), 0);
      check("bad_len_cpu_held", 32'(cpu_n_rst), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      wd = words[i];
      exp_q.push_back({16'(i), wd});
      send_byte(wd[7:0], gaps);
      send_byte(wd[15:8], gaps);
    end
  endtask

  // Runs the CPU phase: halt_at is the 1-based RUN cycle where cpu_halt is
  // raised (0 or beyond the limit means never). Model: a halt on cycle k
  // within the limit ends the run with cycles=k-1 and no timeout; otherwise
  // the run lasts MAXC cycles and ends with cycles=MAXC and timeout.
  task automatic run_cpu(input int halt_at);
    int n = 0;
    int budget = 0;
    bit halted;
    int exp_cyc;
    halted  = (halt_at >= 1) && (halt_at <= MAXC);
    exp_cyc = halted ? halt_at - 1 : MAXC;
    @(negedge clk);
    while (!(cpu_n_rst && !done) && budget < 16) begin
      @(negedge clk);
      budget++;
    end
    check("writes_before_run", exp_q.size(), 0);
    check("run_entered", 32'(cpu_n_rst && !done), 1);
    while (cpu_n_rst && !done && n < MAXC + 4) begin
      n++;
      check("run_cycles", cycles, 32'(n - 1));
      check("run_ready_low", 32'(in_ready), 0);
      cpu_halt = (n == halt_at);
      @(negedge clk);
    end
    cpu_halt = 1'b0;
    check("run_length", n, halted ? halt_at : MAXC);
    check("done", 32'(done), 1);
    check("final_cycles", cycles, 32'(exp_cyc));
    check("final_timeout", 32'(timeout), 32'(!halted));
    check("done_cpu_running", 32'(cpu_n_rst), 1);
    check("done_ready", 32'(in_ready), 1);
    repeat (3) @(negedge clk);
    check("hold_cycles", cycles, 32'(exp_cyc));
    check("hold_timeout", 32'(timeout), 32'(!halted));
    check("hold_done", 32'(done), 1);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] w[$];
    logic [2:0]  st_err;
    int          n;
    int          pick;

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("por");

    // Load test, in_valid held high
    w = '{16'h1234, 16'hABCD, 16'h0001};
    wlog.delete();
    load_prog(3, w, 1'b0);
    // Halt on the 11th RUN cycle
    run_cpu(11);
    check("load_write_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("load_w0", wlog[0], 32'h0000_1234);
      check("load_w1", wlog[1], 32'h0001_ABCD);
      check("load_w2", wlog[2], 32'h0002_0001);
    end
    check("halt_cycles_lit", cycles, 32'd10);
    check("halt_timeout_lit", 32'(timeout), 0);

    // Restart from DONE: 01 00 EF BE, then run to the limit
    wlog.delete();
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    check("restart_done_clr", 32'(done), 0);
    check("restart_timeout_clr", 32'(timeout), 0);
    check("restart_cycles_clr", cycles, 0);
    check("restart_ready", 32'(in_ready), 1);
    exp_q.push_back(32'h0000_BEEF);
    send_byte(8'h00, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    run_cpu(0);
    check("restart_write_count", wlog.size(), 1);
    if (wlog.size() == 1) check("restart_w0", wlog[0], 32'h0000_BEEF);
    check("timeout_cycles_lit", cycles, 32'd16);
    check("timeout_flag_lit", 32'(timeout), 1);

    // From a timed-out DONE: random program, halt coinciding with the limit
    n = $urandom_range(1, 6);
    rand_words(n, w);
    load_prog(n, w, 1'b1);
    run_cpu(MAXC);
    check("coincide_cycles_lit", cycles, 32'd15);
    check("coincide_timeout_lit", 32'(timeout), 0);

    // Back-pressure: same program as the load test with random gaps
    do_reset();
    wlog.delete();
    w = '{16'h1234, 16'hABCD, 16'h0001};
    load_prog(3, w, 1'b1);
    run_cpu($urandom_range(1, 20));
    check("bp_write_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("bp_w0", wlog[0], 32'h0000_1234);
      check("bp_w1", wlog[1], 32'h0001_ABCD);
      check("bp_w2", wlog[2], 32'h0002_0001);
    end

    // Reset while in DATA_HI of the second word
    do_reset();
    exp_q.push_back(32'h0000_2211);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    do_reset();
    repeat (5) @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 1);
    check("post_rst_cpu_held", 32'(cpu_n_rst), 0);
    w = '{16'h5544};
    wlog.delete();
    load_prog(1, w, 1'b0);
    run_cpu(2);
    check("post_rst_write_count", wlog.size(), 1);
    if (wlog.size() == 1) check("post_rst_w0", wlog[0], 32'h0000_5544);

    // Largest legal program: 2**ADDR_W words
    do_reset();
    rand_words(DEPTH, w);
    wlog.delete();
    load_prog(DEPTH, w, 1'b0);
    run_cpu(1);
    check("max_len_write_count", wlog.size(), DEPTH);
    if (wlog.size() == DEPTH) check("max_len_last_addr", 32'(wlog[DEPTH-1][31:16]), 32'd255);

    // Bad length 0, then hold in_valid and check the error sticks
    do_reset();
    w.delete();
    load_prog(0, w, 1'b0);
    st_err = dbg_state;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("err_sticky", 32'(err), 1);
    check("err_state_stable", 32'(dbg_state), 32'(st_err));

    // Bad length 257
    do_reset();
    load_prog(257, w, 1'b0);

    // Randomized mix of legal and illegal programs
    repeat (6) begin
      do_reset();
      pick = $urandom_range(0, 3);
      if (pick == 0)      n = 257 + $urandom_range(0, 1000);
      else if (pick == 1) n = 0;
      else                n = $urandom_range(1, 12);
      if (len_legal(n)) rand_words(n, w);
      else w.delete();
      load_prog(n, w, 1'b1);
      if (len_legal(n)) run_cpu($urandom_range(0, 20));
    end

    check("final_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
